sipo_deser: RTL and testbench

Parametrised serial-to-parallel deserializer. It is the next generation of the plain shift-register SIPO.
- Adds a qualified serial input, word framing via a bit counter, and runtime MSB/LSB-first ordering.
- Output is a one-entry valid/ready holding register with overflow detection.
- Sits between a bit-serial receiver front end and word-oriented downstream logic.

---
 rtl/sipo_pkg.sv | 14 +
 rtl/sipo_out_buf.sv | 35 +++
 rtl/sipo_deser.sv | 89 ++++++++
 tb/tb_sipo_deser.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
// Bit-ordering codes and the bit-counter width helper.
package sipo_pkg;

    localparam logic ORDER_LSB_FIRST = 1'b0;
    localparam logic ORDER_MSB_FIRST = 1'b1;

    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w);
        return (c > 1) ? c : 1;
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for assembled words.
// A load that arrives while a word is still held and not taken is dropped.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             drop
);

    logic xfer;

    assign xfer = out_valid && out_ready;
    assign drop = load && out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with per-word bit ordering,
// abort, and a valid/ready output register with sticky overflow.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             msb_first,
    input  logic             clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             mode_q;
    logic             mode;
    logic             first;
    logic             last;
    logic             take;
    logic             load;
    logic             drop;

    assign take  = in_valid && !clr;
    assign first = (bit_cnt == '0);
    assign last  = (bit_cnt == CNT_W'(WIDTH - 1));
    assign load  = take && last;
    assign busy  = !first;

    // The first bit of a word uses the live pin; later bits use the latch.
    assign mode = first ? msb_first : mode_q;

    always_comb begin
        shift_nxt = shift_reg;
        if (mode == ORDER_MSB_FIRST) begin
            shift_nxt = {shift_reg[WIDTH-2:0], in_bit};
        end else begin
            shift_nxt = {in_bit, shift_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            mode_q    <= ORDER_LSB_FIRST;
            overflow  <= 1'b0;
        end else if (clr) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (take) begin
                shift_reg <= shift_nxt;
                bit_cnt   <= last ? '0 : bit_cnt + CNT_W'(1);
                if (first) begin
                    mode_q <= msb_first;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    sipo_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(shift_nxt),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .drop     (drop)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser at WIDTH=8.
module tb_sipo_deser;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_bit;
    logic       msb_first;
    logic       clr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       busy;

    int n_vec;
    int n_err;
    logic [7:0] sb[$];

    sipo_deser #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .msb_first(msb_first),
        .clr      (clr),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Transfers happen on the next posedge when valid && ready now.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_xfer", 32'(out_valid), 32'd0);
            end else begin
                chk("xfer_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic msb);
        in_valid  = 1'b1;
        in_bit    = b;
        msb_first = msb;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic msb);
        for (int i = 0; i < 8; i++) begin
            send_bit(msb ? w[7-i] : w[i], msb);
        end
    endtask

    logic [7:0] a5;
    logic [7:0] w34;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        msb_first = 1'b1;
        clr       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // ordering
        sb.push_back(8'hC0);
        send_word(8'hC0, 1'b1);
        chk("msb_valid", 32'(out_valid), 32'd1);
        chk("msb_data", 32'(out_data), 32'hC0);
        tick();
        chk("msb_pulse", 32'(out_valid), 32'd0);
        sb.push_back(8'h03);
        send_word(8'h03, 1'b0);
        chk("lsb_valid", 32'(out_valid), 32'd1);
        chk("lsb_data", 32'(out_data), 32'h03);
        tick();
        chk("lsb_pulse", 32'(out_valid), 32'd0);

        // gaps and mode latch
        a5 = 8'hA5;
        sb.push_back(a5);
        for (int i = 0; i < 8; i++) begin
            send_bit(a5[7-i], (i < 3) ? 1'b1 : 1'b0);
            chk("gap_busy", 32'(busy), (i < 7) ? 32'd1 : 32'd0);
            if (i == 7) begin
                chk("gap_valid", 32'(out_valid), 32'd1);
                chk("gap_data", 32'(out_data), 32'hA5);
            end
            tick();
        end
        chk("gap_drained", 32'(out_valid), 32'd0);

        // overflow / back-pressure
        out_ready = 1'b0;
        sb.push_back(8'h12);
        send_word(8'h12, 1'b1);
        chk("bp_ovf0", 32'(overflow), 32'd0);
        send_word(8'h34, 1'b1);
        chk("bp_data", 32'(out_data), 32'h12);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_ovf1", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drain", 32'(out_valid), 32'd0);
        tick();
        chk("bp_sticky", 32'(overflow), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("bp_clr", 32'(overflow), 32'd0);

        // simultaneous completion and transfer
        sb.push_back(8'h12);
        send_word(8'h12, 1'b1);
        w34 = 8'h34;
        sb.push_back(w34);
        for (int i = 0; i < 7; i++) begin
            send_bit(w34[7-i], 1'b1);
        end
        out_ready = 1'b1;
        send_bit(w34[0], 1'b1);
        out_ready = 1'b0;
        chk("sim_data", 32'(out_data), 32'h34);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("sim_drain", 32'(out_valid), 32'd0);

        // abort with pending word
        out_ready = 1'b0;
        sb.push_back(8'h99);
        send_word(8'h99, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 1'b1);
        end
        chk("abt_busy0", 32'(busy), 32'd1);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("abt_busy1", 32'(busy), 32'd0);
        chk("abt_keep_v", 32'(out_valid), 32'd1);
        chk("abt_keep_d", 32'(out_data), 32'h99);
        out_ready = 1'b1;
        sb.push_back(8'h5A);
        send_word(8'h5A, 1'b1);
        chk("abt_data", 32'(out_data), 32'h5A);
        chk("abt_valid", 32'(out_valid), 32'd1);
        chk("abt_ovf", 32'(overflow), 32'd0);
        tick();
        chk("abt_single", 32'(out_valid), 32'd0);

        // reset mid-word and mid-handshake
        out_ready = 1'b0;
        send_word(8'h77, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_bit(i[0], 1'b1);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_data", 32'(out_data), 32'd0);
        chk("mr_ovf", 32'(overflow), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        sb.push_back(8'h81);
        send_word(8'h81, 1'b1);
        chk("mr_word", 32'(out_data), 32'h81);
        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
